// File: rtl/lockstep_alu_checker.sv
// -----------------------------------------------------------------------------
// lockstep_alu_checker
//   NUM_CH redundant ALU channels (add/sub/and/or) behind a 2-stage valid/ready
//   pipeline. Stage 1 registers each channel's {carry,result}. Stage 2 registers
//   the selected (or voted) value and the per-channel disagreement mask. Each
//   mismatching result bumps a saturating error counter and a consecutive-fault
//   counter, which drive an OK / DEGRADED / LOCKED fault state machine.
//
//   Optional feature macro: ALU_VOTE_EN
//     defined   : NUM_CH must be 3; output is the bitwise 2-of-3 majority and
//                 mask bit i flags channel i differing from the voted value.
//     undefined : output is channel 0; mask bit i flags channel i != channel 0.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    operand handshake
//   a_bus, b_bus         per-channel operands, channel i at [i*WIDTH +: WIDTH]
//   sel_bus              per-channel opcode, channel i at [i*2 +: 2]
//   out_valid/out_ready  result handshake
//   res, carry           result and carry/borrow
//   mismatch_mask        per-channel disagreement for the current result
//   res_fault            OR of mismatch_mask
//   fault_state          00 OK, 01 DEGRADED, 10 LOCKED
//   err_cnt              saturating count of mismatching results
//   clr_fault            pulse: clear counters and return to OK
// -----------------------------------------------------------------------------
module lockstep_alu_checker #(
    parameter int WIDTH       = 8,
    parameter int NUM_CH      = 2,
    parameter int FAULT_LIMIT = 4,
    parameter int CNT_W       = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_CH*WIDTH-1:0]   a_bus,
    input  logic [NUM_CH*WIDTH-1:0]   b_bus,
    input  logic [NUM_CH*2-1:0]       sel_bus,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          res,
    output logic                      carry,
    output logic [NUM_CH-1:0]         mismatch_mask,
    output logic                      res_fault,
    output logic [1:0]                fault_state,
    output logic [CNT_W-1:0]          err_cnt,
    input  logic                      clr_fault
);

    typedef enum logic [1:0] {
        ST_OK       = 2'b00,
        ST_DEGRADED = 2'b01,
        ST_LOCKED   = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(FAULT_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

`ifdef ALU_VOTE_EN
    if (NUM_CH != 3) begin : g_vote_bad_num_ch
        $error("lockstep_alu_checker: ALU_VOTE_EN requires NUM_CH == 3");
    end
`endif

    // One ALU channel; bit WIDTH is carry (add) or borrow (sub, set iff a < b).
    function automatic logic [WIDTH:0] alu_op(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [1:0]       sel);
        logic [WIDTH:0] r;
        case (sel)
            2'b00:   r = {1'b0, a} + {1'b0, b};
            2'b01:   r = {1'b0, a} - {1'b0, b};
            2'b10:   r = {1'b0, a & b};
            2'b11:   r = {1'b0, a | b};
            default: r = '0;
        endcase
        return r;
    endfunction

    logic [WIDTH:0]    cr_s     [NUM_CH];
    logic [WIDTH:0]    s1_cr_r  [NUM_CH];
    logic              s1_valid_r;
    logic              out_valid_r;
    logic [WIDTH-1:0]  res_r;
    logic              carry_r;
    logic [NUM_CH-1:0] mask_r;
    logic              res_fault_r;
    logic [CNT_W-1:0]  err_cnt_r;
    logic [CNT_W-1:0]  consec_r;
    state_t            state_r;

    logic [WIDTH:0]    ref_s;
    logic [NUM_CH-1:0] mask_s;
    logic              adv_s;
    logic              accept_s;
    logic              count_s;
    logic              mis_s;
    logic [CNT_W-1:0]  consec_inc_s;

    assign adv_s    = !out_valid_r | out_ready;
    assign in_ready = adv_s & (state_r != ST_LOCKED);
    assign accept_s = in_valid & in_ready;
    // A result is counted on the same edge it moves from stage 1 to stage 2.
    assign count_s  = adv_s & s1_valid_r;
    assign mis_s    = |mask_s;
    assign consec_inc_s = (consec_r == CNT_MAX) ? consec_r : consec_r + {{(CNT_W-1){1'b0}}, 1'b1};

    // Per-channel ALU results for the operands currently presented.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cr_s[i] = alu_op(a_bus[i*WIDTH +: WIDTH], b_bus[i*WIDTH +: WIDTH], sel_bus[i*2 +: 2]);
        end
    end

    // Reference value (channel 0 or majority vote) and per-channel disagreement.
    always_comb begin
`ifdef ALU_VOTE_EN
        ref_s = (s1_cr_r[0] & s1_cr_r[1]) | (s1_cr_r[0] & s1_cr_r[2]) | (s1_cr_r[1] & s1_cr_r[2]);
`else
        ref_s = s1_cr_r[0];
`endif
        mask_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            mask_s[i] = (s1_cr_r[i] != ref_s);
        end
    end

    // Two-stage pipeline; both stages hold together whenever the output stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_r  <= 1'b0;
            out_valid_r <= 1'b0;
            res_r       <= '0;
            carry_r     <= 1'b0;
            mask_r      <= '0;
            res_fault_r <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                s1_cr_r[i] <= '0;
            end
        end else if (adv_s) begin
            s1_valid_r  <= accept_s;
            out_valid_r <= s1_valid_r;
            if (accept_s) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    s1_cr_r[i] <= cr_s[i];
                end
            end
            if (s1_valid_r) begin
                res_r       <= ref_s[WIDTH-1:0];
                carry_r     <= ref_s[WIDTH];
                mask_r      <= mask_s;
                res_fault_r <= mis_s;
            end
        end
    end

    // Error counters and fault FSM; clr_fault beats a coincident counted result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_r <= '0;
            consec_r  <= '0;
            state_r   <= ST_OK;
        end else if (clr_fault) begin
            err_cnt_r <= '0;
            consec_r  <= '0;
            state_r   <= ST_OK;
        end else if (count_s) begin
            if (mis_s) begin
                err_cnt_r <= (err_cnt_r == CNT_MAX) ? err_cnt_r : err_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                consec_r  <= consec_inc_s;
                case (state_r)
                    ST_OK, ST_DEGRADED: state_r <= (consec_inc_s >= LIMIT) ? ST_LOCKED : ST_DEGRADED;
                    ST_LOCKED:          state_r <= ST_LOCKED;
                    default:            state_r <= ST_LOCKED;
                endcase
            end else begin
                consec_r <= '0;
            end
        end
    end

    assign out_valid     = out_valid_r;
    assign res           = res_r;
    assign carry         = carry_r;
    assign mismatch_mask = mask_r;
    assign res_fault     = res_fault_r;
    assign fault_state   = state_r;
    assign err_cnt       = err_cnt_r;

endmodule
